// File: rtl/cru_pkg.sv
// Shared constants and types for the clock-reset-unit divider bank.
// Imported by the channel and the bank top level.
package cru_pkg;

    localparam int DIV_W_DEF = 16;
    localparam int DIV_MIN   = 2;

    typedef logic [DIV_W_DEF-1:0] div_t;

endpackage : cru_pkg

// File: rtl/cru_div_channel.sv
// One divider channel: a period counter with glitch-free divisor hand-over,
// registered enable/divided-clock outputs, and a stretched downstream reset.
module cru_div_channel
    import cru_pkg::*;
#(
    parameter int               DIV_W       = DIV_W_DEF,
    parameter logic [DIV_W-1:0] M_INIT      = DIV_W'(2),
    parameter int               RST_STRETCH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_val,
    input  logic             sync,
    output logic             en,
    output logic             clk_div,
    output logic             rst
);

    localparam int PC_W = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] m_r;
    logic [DIV_W-1:0] pend_r;
    logic             pend_vld_r;
    logic             en_r;
    logic             clk_r;
    logic             rst_r;
    logic [PC_W-1:0]  pulse_cnt_r;

    logic [DIV_W-1:0] cnt_s;
    logic [DIV_W-1:0] m_s;
    logic [DIV_W-1:0] pend_s;
    logic             pend_vld_s;
    logic             en_s;
    logic             clk_s;
    logic             rst_s;
    logic [PC_W-1:0]  pulse_cnt_s;
    logic             wrap_s;

    assign wrap_s = (cnt_r == (m_r - DIV_W'(1)));

    // Counter, divisor hand-over and output decode for the next cycle.
    always_comb begin
        cnt_s       = cnt_r;
        m_s         = m_r;
        pend_s      = pend_r;
        pend_vld_s  = pend_vld_r;
        en_s        = 1'b0;
        clk_s       = clk_r;
        if (sync) begin
            // The sync edge itself serves as the count-0 cycle, so every
            // channel restarts with a full-length high phase and period.
            if (wr_en) begin
                m_s = wr_val;
            end else if (pend_vld_r) begin
                m_s = pend_r;
            end else begin
                m_s = m_r;
            end
            pend_vld_s = 1'b0;
            cnt_s      = DIV_W'(1);
            clk_s      = 1'b1;
            en_s       = 1'b0;
        end else begin
            if (wr_en) begin
                pend_s     = wr_val;
                pend_vld_s = 1'b1;
            end else begin
                pend_s     = pend_r;
                pend_vld_s = pend_vld_r;
            end
            clk_s = (cnt_r < (m_r >> 1));
            if (wrap_s) begin
                cnt_s = '0;
                en_s  = 1'b1;
                // A write landing on the wrap edge stays pending for the next wrap.
                if (pend_vld_r) begin
                    m_s        = pend_r;
                    pend_vld_s = wr_en;
                end else begin
                    m_s = m_r;
                end
            end else begin
                cnt_s = cnt_r + DIV_W'(1);
            end
        end
    end

    // Downstream reset release after RST_STRETCH enable pulses.
    always_comb begin
        rst_s       = rst_r;
        pulse_cnt_s = pulse_cnt_r;
        if (en_s && rst_r) begin
            if (pulse_cnt_r == PC_W'(RST_STRETCH - 1)) begin
                rst_s = 1'b0;
            end else begin
                pulse_cnt_s = pulse_cnt_r + PC_W'(1);
            end
        end else begin
            rst_s       = rst_r;
            pulse_cnt_s = pulse_cnt_r;
        end
    end

    // Channel state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r       <= '0;
            m_r         <= M_INIT;
            pend_r      <= '0;
            pend_vld_r  <= 1'b0;
            en_r        <= 1'b0;
            clk_r       <= 1'b0;
            rst_r       <= 1'b1;
            pulse_cnt_r <= '0;
        end else begin
            cnt_r       <= cnt_s;
            m_r         <= m_s;
            pend_r      <= pend_s;
            pend_vld_r  <= pend_vld_s;
            en_r        <= en_s;
            clk_r       <= clk_s;
            rst_r       <= rst_s;
            pulse_cnt_r <= pulse_cnt_s;
        end
    end

    assign en      = en_r;
    assign clk_div = clk_r;
    assign rst     = rst_r;

endmodule : cru_div_channel

// File: rtl/cru_divider_bank.sv
// Multi-channel clock-enable / divided-clock generator with per-channel reset
// sequencing; holds the write decode, error flag and sync fan-out.
module cru_divider_bank
    import cru_pkg::*;
#(
    parameter int                      N_CH        = 4,
    parameter int                      DIV_W       = DIV_W_DEF,
    parameter logic [N_CH*DIV_W-1:0]   DIV_INIT    = {16'd30, 16'd6, 16'd20, 16'd250},
    parameter int                      RST_STRETCH = 4,
    // One spare code point so an out-of-range channel can be addressed and rejected.
    localparam int                     SEL_W       = $clog2(N_CH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_wr,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [DIV_W-1:0] div_val,
    input  logic             sync_i,
    output logic             err_o,
    output logic [N_CH-1:0]  en_o,
    output logic [N_CH-1:0]  clk_o,
    output logic [N_CH-1:0]  rst_o
);

    logic            sel_ok_s;
    logic            val_ok_s;
    logic            wr_ok_s;
    logic [N_CH-1:0] wr_ch_s;
    logic            err_r;

    assign sel_ok_s = (div_sel < SEL_W'(N_CH));
    assign val_ok_s = (div_val >= DIV_W'(DIV_MIN));
    assign wr_ok_s  = div_wr & sel_ok_s & val_ok_s;

    // Rejected-write flag, one cycle after the offending strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= div_wr & ~(sel_ok_s & val_ok_s);
        end
    end

    assign err_o = err_r;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign wr_ch_s[g] = wr_ok_s & (div_sel == SEL_W'(g));

        cru_div_channel #(
            .DIV_W       (DIV_W),
            .M_INIT      (DIV_INIT[g*DIV_W +: DIV_W]),
            .RST_STRETCH (RST_STRETCH)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_ch_s[g]),
            .wr_val  (div_val),
            .sync    (sync_i),
            .en      (en_o[g]),
            .clk_div (clk_o[g]),
            .rst     (rst_o[g])
        );
    end

endmodule : cru_divider_bank

// File: tb/tb_cru_divider_bank.sv
// Directed bench for cru_divider_bank: periods, duty, reset sequencing,
// runtime divisor changes, illegal writes, sync and mid-run reset.
module tb_cru_divider_bank;

    localparam int N_CH  = 4;
    localparam int DIV_W = 16;
    localparam int SEL_W = 3;

    logic             clk;
    logic             reset;
    logic             div_wr;
    logic [SEL_W-1:0] div_sel;
    logic [DIV_W-1:0] div_val;
    logic             sync_i;
    logic             err_o;
    logic [N_CH-1:0]  en_o;
    logic [N_CH-1:0]  clk_o;
    logic [N_CH-1:0]  rst_o;

    cru_divider_bank dut (
        .clk     (clk),
        .reset   (reset),
        .div_wr  (div_wr),
        .div_sel (div_sel),
        .div_val (div_val),
        .sync_i  (sync_i),
        .err_o   (err_o),
        .en_o    (en_o),
        .clk_o   (clk_o),
        .rst_o   (rst_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk;
    int n_pass;
    int cyc;
    int en_first [N_CH];
    int en_last  [N_CH];
    int en_per   [N_CH];
    int per_min  [N_CH];
    int per_max  [N_CH];
    int hi_len   [N_CH];
    int lo_len   [N_CH];
    int run_len  [N_CH];
    int rise_first [N_CH];
    int rst_fall [N_CH];
    bit clk_prev [N_CH];
    bit rst_prev [N_CH];
    int err_n;
    int s;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < N_CH; i++) begin
            en_first[i]   = -1;
            en_last[i]    = -1;
            en_per[i]     = -1;
            per_min[i]    = 1 << 30;
            per_max[i]    = 0;
            hi_len[i]     = -1;
            lo_len[i]     = -1;
            run_len[i]    = -1;
            rise_first[i] = -1;
            rst_fall[i]   = -1;
            clk_prev[i]   = clk_o[i];
            rst_prev[i]   = rst_o[i];
        end
        err_n = 0;
    endtask

    // Advance one cycle; sample on the falling edge and update the monitor.
    task automatic tick();
        int p;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N_CH; i++) begin
            if (en_o[i]) begin
                if (en_last[i] >= 0) begin
                    p = cyc - en_last[i];
                    en_per[i] = p;
                    if (p < per_min[i]) per_min[i] = p;
                    if (p > per_max[i]) per_max[i] = p;
                end else begin
                    en_first[i] = cyc;
                end
                en_last[i] = cyc;
            end
            if (clk_o[i] != clk_prev[i]) begin
                if (run_len[i] >= 0) begin
                    if (clk_prev[i]) hi_len[i] = run_len[i];
                    else             lo_len[i] = run_len[i];
                end
                if (!clk_prev[i] && rise_first[i] < 0) rise_first[i] = cyc;
                run_len[i] = 1;
            end else if (run_len[i] >= 0) begin
                run_len[i]++;
            end
            clk_prev[i] = clk_o[i];
            if (rst_prev[i] && !rst_o[i]) rst_fall[i] = cyc;
            rst_prev[i] = rst_o[i];
        end
        if (err_o) err_n++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic wr(input int sel, input int val);
        div_wr  = 1'b1;
        div_sel = SEL_W'(sel);
        div_val = DIV_W'(val);
        tick();
        div_wr  = 1'b0;
        div_sel = '0;
        div_val = '0;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        cyc     = 0;
        reset   = 1'b1;
        div_wr  = 1'b0;
        div_sel = '0;
        div_val = '0;
        sync_i  = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_en",  int'(en_o),  0);
        chk("rst_clk", int'(clk_o), 0);
        chk("rst_rst", int'(rst_o), 15);
        chk("rst_err", int'(err_o), 0);

        // Default divisors 250/20/6/30 from reset release.
        reset = 1'b0;
        cyc   = 0;
        clear_mon();
        run_to(1010);
        chk("first_en0", en_first[0], 250);
        chk("first_en1", en_first[1], 20);
        chk("first_en2", en_first[2], 6);
        chk("first_en3", en_first[3], 30);
        chk("per0", en_per[0], 250);
        chk("per1", en_per[1], 20);
        chk("per2", en_per[2], 6);
        chk("per3", en_per[3], 30);
        chk("hi0", hi_len[0], 125);
        chk("lo0", lo_len[0], 125);
        chk("hi1", hi_len[1], 10);
        chk("hi2", hi_len[2], 3);
        chk("lo2", lo_len[2], 3);
        chk("hi3", hi_len[3], 15);
        chk("rise0", rise_first[0], 1);
        chk("rise2", rise_first[2], 1);
        chk("rstfall2", rst_fall[2], 24);
        chk("rstfall1", rst_fall[1], 80);
        chk("rstfall0", rst_fall[0], 1000);
        chk("noerr", err_n, 0);

        // ch1 <- 7 mid-period: the running 20-cycle period finishes first.
        clear_mon();
        wr(1, 7);
        run_to(1021);
        chk("chg_old_end", en_first[1], 1020);
        clear_mon();
        run_to(1070);
        chk("chg_first", en_first[1], 1027);
        chk("chg_pmin", per_min[1], 7);
        chk("chg_pmax", per_max[1], 7);
        chk("chg_hi", hi_len[1], 3);
        chk("chg_lo", lo_len[1], 4);

        // Back-to-back writes to ch3 before its wrap; only the last counts.
        run_to(1085);
        wr(3, 10);
        run_to(1090);
        wr(3, 12);
        run_to(1100);
        clear_mon();
        run_to(1160);
        chk("b2b_first", en_first[3], 1110);
        chk("b2b_pmin", per_min[3], 12);
        chk("b2b_pmax", per_max[3], 12);

        // Illegal writes: divisor below 2, channel out of range.
        clear_mon();
        wr(2, 1);
        chk("err_val", int'(err_o), 1);
        tick();
        chk("err_pulse", int'(err_o), 0);
        wr(4, 8);
        chk("err_sel", int'(err_o), 1);
        run_to(1690);
        chk("err_count", err_n, 2);
        chk("ill_per0", en_per[0], 250);
        chk("ill_per1", en_per[1], 7);
        chk("ill_per2", en_per[2], 6);
        chk("ill_per3", en_per[3], 12);

        // Restore ch1 to 20, then sync together with ch0 <- 40.
        wr(1, 20);
        run_to(1700);
        s       = cyc;
        sync_i  = 1'b1;
        wr(0, 40);
        sync_i  = 1'b0;
        chk("sync_clk", int'(clk_o), 15);
        chk("sync_en",  int'(en_o), 0);
        chk("sync_rst", int'(rst_o), 0);
        clear_mon();
        run_to(s + 130);
        chk("sync_en0", en_first[0] - s, 40);
        chk("sync_per0", en_per[0], 40);
        chk("sync_en1", en_first[1] - s, 20);
        chk("sync_en2", en_first[2] - s, 6);
        chk("sync_en3", en_first[3] - s, 12);
        chk("sync_hi0", hi_len[0], 20);
        chk("sync_lo0", lo_len[0], 20);

        // Reset for one cycle while writes are pending.
        wr(1, 50);
        wr(3, 9);
        reset = 1'b1;
        tick();
        chk("mrst_en",  int'(en_o),  0);
        chk("mrst_clk", int'(clk_o), 0);
        chk("mrst_rst", int'(rst_o), 15);
        chk("mrst_err", int'(err_o), 0);
        reset = 1'b0;
        cyc   = 0;
        clear_mon();
        run_to(260);
        chk("mrst_first0", en_first[0], 250);
        chk("mrst_first1", en_first[1], 20);
        chk("mrst_first2", en_first[2], 6);
        chk("mrst_first3", en_first[3], 30);
        chk("mrst_per1", en_per[1], 20);
        chk("mrst_per3", en_per[3], 30);
        chk("mrst_rise1", rise_first[1], 1);
        chk("mrst_rstfall2", rst_fall[2], 24);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_cru_divider_bank
